// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int LATENCY_MAX = 15;

  typedef logic [$clog2(LATENCY_MAX + 1)-1:0] lat_cnt_t;

  localparam logic [31:0] MMIO_GPIO  = 32'h0000_0000;
  localparam logic [31:0] MMIO_CYCLE = 32'h0000_0004;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-to-memory request/response bus: the core is the master, the responder the slave.
interface data_mem_responder_if;

  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        mem_valid;
  logic [31:0] rdata;

  modport master (output sel, we, addr, wdata, wmask, input mem_valid, rdata);
  modport slave  (input sel, we, addr, wdata, wmask, output mem_valid, rdata);

endinterface

// File: rtl/ram_1rw_bytemask.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read port.
module ram_1rw_bytemask #(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     re,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array itself is never reset; a reset port on it would stop it mapping to block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Output register only updates on a load, so it holds the last load's word.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency responder for the core's data-memory port: word RAM plus a GPIO/cycle-counter MMIO window.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
  parameter string       INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  output logic [15:0]          gpio_out
);

  localparam int       AW       = $clog2(DEPTH_WORDS);
  localparam lat_cnt_t CNT_LOAD = (LATENCY > 1) ? lat_cnt_t'(LATENCY - 2) : '0;

  state_t      state, state_nxt;
  lat_cnt_t    cnt;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic        accept, enter_resp, commit;
  logic        cur_we, cur_mmio, req_mmio;
  logic [31:0] cur_addr, cur_off, req_off;
  logic [31:0] gpio_q, cycle_q, mmio_rdata, ram_rdata;
  logic        resp_mmio;
  logic        ram_re;
  logic [3:0]  ram_we;
  logic [AW-1:0] ram_addr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.sel) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_valid = (state == RESP);
    accept        = (state == IDLE) && bus.sel;
    enter_resp    = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == '0));
    commit        = (state == RESP) && req_we && !rst;
  end

  // With LATENCY=1 the read happens on the acceptance edge, so the live bus feeds the decode in IDLE.
  assign cur_we   = (state == IDLE) ? bus.we   : req_we;
  assign cur_addr = (state == IDLE) ? bus.addr : req_addr;
  assign cur_mmio = cur_addr >= MMIO_BASE;
  assign cur_off  = {cur_addr[31:2], 2'b00} - MMIO_BASE;
  assign req_mmio = req_addr >= MMIO_BASE;
  assign req_off  = {req_addr[31:2], 2'b00} - MMIO_BASE;

  assign ram_addr = cur_addr[AW+1:2];
  assign ram_re   = enter_resp && !cur_we && !cur_mmio;
  assign ram_we   = (commit && !req_mmio) ? req_wmask : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wmask <= '0;
    end else if (accept) begin
      cnt       <= CNT_LOAD;
      req_we    <= bus.we;
      req_addr  <= bus.addr;
      req_wdata <= bus.wdata;
      req_wmask <= bus.wmask;
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - lat_cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q  <= '0;
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (commit && req_mmio && (req_off == MMIO_GPIO)) begin
        for (int i = 0; i < 4; i++) begin
          if (req_wmask[i]) gpio_q[8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Stores leave both read sources untouched, so rdata keeps the last load's value.
  always_ff @(posedge clk) begin
    if (rst) begin
      mmio_rdata <= '0;
      resp_mmio  <= 1'b0;
    end else if (enter_resp && !cur_we) begin
      resp_mmio <= cur_mmio;
      if (cur_mmio) begin
        if (cur_off == MMIO_GPIO)       mmio_rdata <= gpio_q;
        else if (cur_off == MMIO_CYCLE) mmio_rdata <= cycle_q;
        else                            mmio_rdata <= '0;
      end
    end
  end

  ram_1rw_bytemask #(
    .DEPTH     (DEPTH_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  assign bus.rdata = resp_mmio ? mmio_rdata : ram_rdata;
  assign gpio_out  = gpio_q[15:0];

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: three responders (LATENCY 1, 4, 3) driven one at a time from a shared request bus.
module tb_data_mem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  int          act = 0;
  logic [15:0] gpio0, gpio1, gpio2;

  int          checks = 0;
  int          failures = 0;
  int          tcyc = 0;
  logic [31:0] cyc_m = '0;

  typedef struct {
    bit          is_store;
    logic [31:0] data;
    int          exp_cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [3][1024];
  logic [31:0] gpio_m [3];
  logic [31:0] last_rd [3];

  data_mem_responder_if if0 ();
  data_mem_responder_if if1 ();
  data_mem_responder_if if2 ();

  assign if0.sel = sel && (act == 0);
  assign if1.sel = sel && (act == 1);
  assign if2.sel = sel && (act == 2);
  assign if0.we = we;       assign if1.we = we;       assign if2.we = we;
  assign if0.addr = addr;   assign if1.addr = addr;   assign if2.addr = addr;
  assign if0.wdata = wdata; assign if1.wdata = wdata; assign if2.wdata = wdata;
  assign if0.wmask = wmask; assign if1.wmask = wmask; assign if2.wmask = wmask;

  data_mem_responder #(.LATENCY(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0), .gpio_out(gpio0));
  data_mem_responder #(.LATENCY(4)) u_dut1 (.clk(clk), .rst(rst), .bus(if1), .gpio_out(gpio1));
  data_mem_responder #(.LATENCY(3)) u_dut2 (.clk(clk), .rst(rst), .bus(if2), .gpio_out(gpio2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tcyc  <= tcyc + 1;
    cyc_m <= rst ? 32'd0 : cyc_m + 32'd1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : (d == 1) ? 4 : 3;
  endfunction

  function automatic logic get_mv(int d);
    case (d)
      0:       return if0.mem_valid;
      1:       return if1.mem_valid;
      default: return if2.mem_valid;
    endcase
  endfunction

  function automatic logic [31:0] get_rd(int d);
    case (d)
      0:       return if0.rdata;
      1:       return if1.rdata;
      default: return if2.rdata;
    endcase
  endfunction

  function automatic logic [15:0] get_gpio(int d);
    case (d)
      0:       return gpio0;
      1:       return gpio1;
      default: return gpio2;
    endcase
  endfunction

  function automatic logic [31:0] model_read(int d, logic [31:0] a, int cyc_ofs);
    logic [31:0] off;
    if (a >= BASE) begin
      off = {a[31:2], 2'b00} - BASE;
      if (off == 32'h0) return gpio_m[d];
      if (off == 32'h4) return cyc_m + 32'(cyc_ofs);
      return 32'h0;
    end
    return mem_m[d][a[11:2]];
  endfunction

  function automatic void model_store(int d, logic [31:0] a, logic [31:0] wd, logic [3:0] m);
    logic [31:0] off;
    off = {a[31:2], 2'b00} - BASE;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (a < BASE)           mem_m[d][a[11:2]][8*i +: 8] = wd[8*i +: 8];
        else if (off == 32'h0)  gpio_m[d][8*i +: 8] = wd[8*i +: 8];
      end
    end
  endfunction

  // Response monitor: pops the scoreboard on every mem_valid and checks rdata holds otherwise.
  always @(negedge clk) begin
    exp_t        e;
    logic        v;
    logic [31:0] r;
    v = get_mv(act);
    r = get_rd(act);
    if (!rst) begin
      if (v) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL spurious_valid: mem_valid=1 at cycle %0d, required no response", tcyc);
        end else begin
          e = sb.pop_front();
          if (tcyc != e.exp_cyc) begin
            failures++;
            $display("FAIL latency_%s: mem_valid at cycle %0d, required %0d", e.name, tcyc, e.exp_cyc);
          end
          checks++;
          if (e.is_store && (r !== last_rd[act])) begin
            failures++;
            $display("FAIL store_rdata_%s: rdata=%h, required unchanged %h", e.name, r, last_rd[act]);
          end else if (!e.is_store && (r !== e.data)) begin
            failures++;
            $display("FAIL data_%s: rdata=%h, required %h", e.name, r, e.data);
          end
        end
      end else begin
        checks++;
        if (r !== last_rd[act]) begin
          failures++;
          $display("FAIL rdata_hold: rdata=%h at cycle %0d, required %h", r, tcyc, last_rd[act]);
        end
      end
      last_rd[act] = r;
    end
  end

  task automatic drive(int d, bit w, logic [31:0] a, logic [31:0] wd, logic [3:0] m, int delay, string name);
    exp_t e;
    act   = d;
    sel   = 1'b1;
    we    = w;
    addr  = a;
    wdata = wd;
    wmask = m;
    e.is_store = w;
    e.exp_cyc  = tcyc + lat_of(d) + delay;
    e.name     = name;
    e.data     = '0;
    if (w) model_store(d, a, wd, m);
    else   e.data = model_read(d, a, lat_of(d) + delay - 1);
    sb.push_back(e);
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while ((sb.size() != 0) && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL timeout_%s: %0d responses outstanding after 40 cycles, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic req(int d, bit w, logic [31:0] a, logic [31:0] wd, logic [3:0] m, string name);
    wait_idle(name);
    @(negedge clk);
    drive(d, w, a, wd, m, 0, name);
    @(negedge clk);
    sel = 1'b0;
    wait_idle(name);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (get_mv(d) !== 1'b0) begin
        failures++;
        $display("FAIL reset_valid_%0d: mem_valid=%b, required 0", d, get_mv(d));
      end
      checks++;
      if (get_rd(d) !== 32'h0) begin
        failures++;
        $display("FAIL reset_rdata_%0d: rdata=%h, required 0", d, get_rd(d));
      end
      checks++;
      if (get_gpio(d) !== 16'h0) begin
        failures++;
        $display("FAIL reset_gpio_%0d: gpio_out=%h, required 0", d, get_gpio(d));
      end
    end
  endtask

  task automatic test_latency1();
    req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "l1_store");
    req(0, 1'b0, 32'h10, 32'h0, 4'h0, "l1_load");
    checks++;
    if (get_rd(0) !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL l1_readback: rdata=%h, required deadbeef", get_rd(0));
    end
  endtask

  task automatic test_byte_mask();
    req(0, 1'b1, 32'h10, 32'h0000_AA00, 4'b0010, "mask_store");
    req(0, 1'b0, 32'h10, 32'h0, 4'h0, "mask_load");
    checks++;
    if (get_rd(0) !== 32'hDEAD_AAEF) begin
      failures++;
      $display("FAIL mask_readback: rdata=%h, required deadaaef", get_rd(0));
    end
    req(0, 1'b1, 32'h14, 32'h1234_5678, 4'h0, "mask_zero_store");
    req(0, 1'b0, 32'h10, 32'h0, 4'h0, "mask_zero_check");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      req(1, 1'b1, 32'h100 + 32'(4 * i), 32'h1111_0000 * 32'(i + 1) + 32'(i), 4'hF, "b2b_fill");
    end
    wait_idle("b2b_pre");
    @(negedge clk);
    drive(1, 1'b0, 32'h100, 32'h0, 4'h0, 0, "b2b_0");
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      drive(1, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, 4, (i == 1) ? "b2b_1" : "b2b_2");
      repeat (4) @(negedge clk);
    end
    @(negedge clk);
    sel = 1'b0;
    wait_idle("b2b_end");
  endtask

  task automatic test_mmio();
    logic [31:0] c1, c2;
    int          t1;
    req(0, 1'b1, BASE, 32'h1234_5678, 4'hF, "gpio_store");
    checks++;
    if (gpio0 !== 16'h5678) begin
      failures++;
      $display("FAIL gpio_out: gpio_out=%h, required 5678", gpio0);
    end
    req(0, 1'b1, BASE, 32'h00AB_0000, 4'b0100, "gpio_hi_store");
    req(0, 1'b0, BASE, 32'h0, 4'h0, "gpio_load");
    checks++;
    if ((get_rd(0) !== 32'h12AB_5678) || (gpio0 !== 16'h5678)) begin
      failures++;
      $display("FAIL gpio_upper: rdata=%h gpio_out=%h, required 12ab5678 and 5678", get_rd(0), gpio0);
    end
    req(0, 1'b1, BASE + 32'h4, 32'hFFFF_FFFF, 4'hF, "cycle_store");
    wait_idle("cycle_a");
    @(negedge clk);
    t1 = tcyc;
    drive(0, 1'b0, BASE + 32'h4, 32'h0, 4'h0, 0, "cycle_a");
    @(negedge clk);
    sel = 1'b0;
    wait_idle("cycle_a");
    c1 = get_rd(0);
    while (tcyc < t1 + 10) @(negedge clk);
    drive(0, 1'b0, BASE + 32'h4, 32'h0, 4'h0, 0, "cycle_b");
    @(negedge clk);
    sel = 1'b0;
    wait_idle("cycle_b");
    c2 = get_rd(0);
    checks++;
    if (c2 - c1 !== 32'd10) begin
      failures++;
      $display("FAIL cycle_delta: delta=%0d, required 10", c2 - c1);
    end
    req(0, 1'b1, BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, "other_store");
    req(0, 1'b0, BASE + 32'h8, 32'h0, 4'h0, "other_load");
    checks++;
    if (get_rd(0) !== 32'h0) begin
      failures++;
      $display("FAIL other_offset: rdata=%h, required 0", get_rd(0));
    end
  endtask

  task automatic test_wrap();
    req(0, 1'b1, 32'h1000, 32'h5A5A_1234, 4'hF, "wrap_store");
    req(0, 1'b0, 32'h0, 32'h0, 4'h0, "wrap_load");
    checks++;
    if (get_rd(0) !== 32'h5A5A_1234) begin
      failures++;
      $display("FAIL wrap_readback: rdata=%h, required 5a5a1234", get_rd(0));
    end
  endtask

  task automatic test_reset_in_wait();
    req(2, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, "rw_store");
    req(2, 1'b1, BASE, 32'h0000_BEEF, 4'b0011, "rw_gpio");
    checks++;
    if (gpio2 !== 16'hBEEF) begin
      failures++;
      $display("FAIL rw_gpio_set: gpio_out=%h, required beef", gpio2);
    end
    wait_idle("rw_pre");
    @(negedge clk);
    act   = 2;
    sel   = 1'b1;
    we    = 1'b1;
    addr  = 32'h40;
    wdata = 32'h1111_1111;
    wmask = 4'hF;
    @(negedge clk);
    sel = 1'b0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      last_rd[d] = '0;
      gpio_m[d]  = '0;
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      checks++;
      if (get_mv(2) !== 1'b0) begin
        failures++;
        $display("FAIL rw_no_valid: mem_valid=%b at cycle %0d, required 0", get_mv(2), tcyc);
      end
      @(negedge clk);
    end
    checks++;
    if ((gpio0 !== 16'h0) || (gpio2 !== 16'h0)) begin
      failures++;
      $display("FAIL rw_gpio_clear: gpio_out0=%h gpio_out2=%h, required 0", gpio0, gpio2);
    end
    req(2, 1'b0, 32'h40, 32'h0, 4'h0, "rw_word");
    checks++;
    if (get_rd(2) !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL rw_word_kept: rdata=%h, required cafef00d", get_rd(2));
    end
    req(2, 1'b0, BASE + 32'h4, 32'h0, 4'h0, "rw_cycle");
    checks++;
    if (get_rd(2) >= 32'd32) begin
      failures++;
      $display("FAIL rw_cycle_restart: cycle=%0d, required below 32", get_rd(2));
    end
    req(0, 1'b0, BASE, 32'h0, 4'h0, "rw_gpio_read");
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      last_rd[d] = '0;
      gpio_m[d]  = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_latency1();
    test_byte_mask();
    test_back_to_back();
    test_mmio();
    test_wrap();
    test_reset_in_wait();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
